// File: rtl/rpn_pkg.sv
// RPN calculator shared types: command, operation and FSM state encodings,
// plus the bit positions of the N/Z/C/V flags inside the 4-bit Flags bus.
package rpn_pkg;

    typedef enum logic [1:0] {
        CMD_PUSH  = 2'b00,
        CMD_OP    = 2'b01,
        CMD_DROP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    // One-hot so the state register can be exported directly.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_EXEC = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/rpn_alu.sv
// Combinational RPN datapath: computes a op b and the {N,Z,C,V} flags.
// Ports: a (second-from-top), b (top), op, result, flags.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           c;
    logic           v;

    // Top bit of the widened difference is the unsigned borrow (a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        unique case (op)
            OP_ADD: begin
                result = sum[MSB:0];
                c      = sum[WIDTH];
                v      = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result = diff[MSB:0];
                c      = diff[WIDTH];
                v      = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[MSB];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/rpn_stack_calculator.sv
// RPN stack calculator: 3-state command FSM, operand stack, depth counter.
// Ports: clk, resetN, Enter/Cmd/OpCode/DataIn in; ToDisplay, Flags, Depth,
// Error, Busy, CurrentState out.
module rpn_stack_calculator
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       Enter,
    input  logic [1:0]                 Cmd,
    input  logic [1:0]                 OpCode,
    input  logic [WIDTH-1:0]           DataIn,
    output logic [WIDTH-1:0]           ToDisplay,
    output logic [3:0]                 Flags,
    output logic [$clog2(DEPTH+1)-1:0] Depth,
    output logic                       Error,
    output logic                       Busy,
    output logic [2:0]                 CurrentState
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    state_t           state;
    cmd_t             cmd_q;
    op_t              op_q;
    logic [WIDTH-1:0] data_q;
    logic [DW-1:0]    depth_q;
    logic [3:0]       flags_q;
    logic             error_q;
    logic             busy_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    sec_idx;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;

    // Indices wrap when depth is too small; those reads are never used.
    assign top_idx = AW'(depth_q - DW'(1));
    assign sec_idx = AW'(depth_q - DW'(2));

    rpn_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (mem[sec_idx]),
        .b      (mem[top_idx]),
        .op     (op_q),
        .result (alu_res),
        .flags  (alu_flags)
    );

    // Stack writes happen only on the edge that leaves EXEC.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if (state == ST_EXEC) begin
            if (cmd_q == CMD_PUSH && depth_q != FULL) begin
                wr_en   = 1'b1;
                wr_idx  = AW'(depth_q);
                wr_data = data_q;
            end else if (cmd_q == CMD_OP && depth_q >= DW'(2)) begin
                wr_en   = 1'b1;
                wr_idx  = sec_idx;
                wr_data = alu_res;
            end
        end
    end

    // Stack RAM carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            cmd_q   <= CMD_PUSH;
            op_q    <= OP_ADD;
            data_q  <= '0;
            depth_q <= '0;
            flags_q <= '0;
            error_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (Enter) begin
                        state  <= ST_EXEC;
                        busy_q <= 1'b1;
                        cmd_q  <= cmd_t'(Cmd);
                        op_q   <= op_t'(OpCode);
                        data_q <= DataIn;
                    end
                end
                ST_EXEC: begin
                    state <= ST_DONE;
                    unique case (cmd_q)
                        CMD_PUSH: begin
                            if (depth_q == FULL) begin
                                error_q <= 1'b1;
                            end else begin
                                depth_q <= depth_q + DW'(1);
                            end
                        end
                        CMD_OP: begin
                            if (depth_q < DW'(2)) begin
                                error_q <= 1'b1;
                            end else begin
                                depth_q <= depth_q - DW'(1);
                                flags_q <= alu_flags;
                            end
                        end
                        CMD_DROP: begin
                            if (depth_q == '0) begin
                                error_q <= 1'b1;
                            end else begin
                                depth_q <= depth_q - DW'(1);
                            end
                        end
                        CMD_CLEAR: begin
                            depth_q <= '0;
                            flags_q <= '0;
                            error_q <= 1'b0;
                        end
                    endcase
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign ToDisplay    = (depth_q == '0) ? DataIn : mem[top_idx];
    assign Flags        = flags_q;
    assign Depth        = depth_q;
    assign Error        = error_q;
    assign Busy         = busy_q;
    assign CurrentState = state;

endmodule

// File: tb/tb_rpn_stack_calculator.sv
// Directed bench for rpn_stack_calculator (WIDTH=16, DEPTH=4).
module tb_rpn_stack_calculator;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic              clk;
    logic              resetN;
    logic              Enter;
    logic [1:0]        Cmd;
    logic [1:0]        OpCode;
    logic [WIDTH-1:0]  DataIn;
    logic [WIDTH-1:0]  ToDisplay;
    logic [3:0]        Flags;
    logic [2:0]        Depth;
    logic              Error;
    logic              Busy;
    logic [2:0]        CurrentState;

    int total;
    int bad;

    rpn_stack_calculator #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .Enter        (Enter),
        .Cmd          (Cmd),
        .OpCode       (OpCode),
        .DataIn       (DataIn),
        .ToDisplay    (ToDisplay),
        .Flags        (Flags),
        .Depth        (Depth),
        .Error        (Error),
        .Busy         (Busy),
        .CurrentState (CurrentState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Issue one command at a negedge and return in IDLE after DONE.
    task automatic issue(input logic [1:0] c, input logic [1:0] o,
                         input logic [15:0] d);
        @(negedge clk);
        Enter  = 1'b1;
        Cmd    = c;
        OpCode = o;
        DataIn = d;
        @(negedge clk);
        Enter = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] d);
        issue(2'b00, 2'b00, d);
    endtask

    task automatic op(input logic [1:0] o);
        issue(2'b01, o, 16'h0);
    endtask

    task automatic drop();
        issue(2'b10, 2'b00, 16'h0);
    endtask

    task automatic clear();
        issue(2'b11, 2'b00, 16'h0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        resetN = 1'b0;
        Enter  = 1'b0;
        Cmd    = 2'b00;
        OpCode = 2'b00;
        DataIn = 16'hABCD;
        repeat (2) @(negedge clk);
        chk("rst_state", CurrentState, 3'b001);
        chk("rst_depth", Depth, 0);
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_err", Error, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_disp", ToDisplay, 16'hABCD);
        resetN = 1'b1;

        push(16'h0003);
        push(16'h0005);
        op(2'b00);
        chk("add_disp", ToDisplay, 16'h0008);
        chk("add_depth", Depth, 1);
        chk("add_flags", Flags, 4'b0000);
        chk("add_err", Error, 0);
        clear();

        push(16'h0003);
        push(16'h0005);
        op(2'b01);
        chk("sub_disp", ToDisplay, 16'hFFFE);
        chk("sub_flags", Flags, 4'b1010);
        clear();

        push(16'h7FFF);
        push(16'h0001);
        op(2'b00);
        chk("ovf_disp", ToDisplay, 16'h8000);
        chk("ovf_flags", Flags, 4'b1001);

        op(2'b10);
        chk("und_err", Error, 1);
        chk("und_depth", Depth, 1);
        chk("und_flags", Flags, 4'b1001);
        chk("und_disp", ToDisplay, 16'h8000);
        push(16'h00F0);
        chk("sticky_err", Error, 1);
        chk("sticky_depth", Depth, 2);
        clear();
        chk("clr_flags", Flags, 4'b0000);

        for (int i = 1; i <= 5; i++) push(16'(i));
        chk("full_err", Error, 1);
        chk("full_depth", Depth, 4);
        chk("full_disp", ToDisplay, 16'h0004);
        clear();
        DataIn = 16'h5A5A;
        #1;
        chk("clr_err", Error, 0);
        chk("clr_depth", Depth, 0);
        chk("clr_disp", ToDisplay, 16'h5A5A);

        push(16'hF0F0);
        push(16'h0FF0);
        op(2'b10);
        chk("and_disp", ToDisplay, 16'h00F0);
        chk("and_flags", Flags, 4'b0000);
        push(16'h0F00);
        op(2'b11);
        chk("or_disp", ToDisplay, 16'h0FF0);
        chk("or_flags", Flags, 4'b0000);
        push(16'h0FF0);
        op(2'b01);
        chk("zero_disp", ToDisplay, 16'h0000);
        chk("zero_flags", Flags, 4'b0100);
        push(16'hFFFF);
        push(16'h0001);
        op(2'b00);
        chk("cy_disp", ToDisplay, 16'h0000);
        chk("cy_flags", Flags, 4'b0110);
        chk("cy_depth", Depth, 2);
        drop();
        drop();
        chk("drop_depth", Depth, 0);
        chk("drop_err0", Error, 0);
        drop();
        chk("drop_err", Error, 1);
        chk("drop_depth0", Depth, 0);
        clear();

        // Enter held through EXEC and DONE with changed inputs.
        @(negedge clk);
        Enter  = 1'b1;
        Cmd    = 2'b00;
        DataIn = 16'h1111;
        @(negedge clk);
        chk("ex_state", CurrentState, 3'b010);
        chk("ex_busy", Busy, 1);
        Cmd    = 2'b10;
        DataIn = 16'h2222;
        @(negedge clk);
        chk("dn_state", CurrentState, 3'b100);
        chk("dn_depth", Depth, 1);
        @(negedge clk);
        Enter = 1'b0;
        chk("id_state", CurrentState, 3'b001);
        chk("id_busy", Busy, 0);
        repeat (2) @(negedge clk);
        chk("ign_depth", Depth, 1);
        chk("ign_disp", ToDisplay, 16'h1111);

        // Asynchronous reset in the middle of a PUSH.
        @(negedge clk);
        Enter  = 1'b1;
        Cmd    = 2'b00;
        DataIn = 16'h3333;
        @(negedge clk);
        Enter = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        chk("ar_state", CurrentState, 3'b001);
        chk("ar_depth", Depth, 0);
        chk("ar_busy", Busy, 0);
        repeat (2) @(negedge clk);
        chk("ar_hold", CurrentState, 3'b001);
        resetN = 1'b1;
        push(16'h4444);
        chk("ar_after", ToDisplay, 16'h4444);
        chk("ar_adepth", Depth, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rpn_stack_calculator.md
RPN_STACK_CALCULATOR -- requirements
Module: rpn_stack_calculator

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk and resetN.
REQ-002 Parameter WIDTH, default 16: data width in bits. Legal values are 4 or more.
REQ-003 Parameter DEPTH, default 8: operand stack depth in entries. Legal values are 2 or more.
REQ-004 clk  in  1  system clock.
REQ-005 resetN  in  1  asynchronous active-low reset.
REQ-006 Enter  in  1  single-cycle command strobe, already debounced and synchronised to clk.
REQ-007 Cmd  in  2  command: 00 PUSH, 01 OP, 10 DROP, 11 CLEAR.
REQ-008 OpCode  in  2  operation for OP: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-009 DataIn  in  WIDTH  operand for PUSH.
REQ-010 ToDisplay  out  WIDTH  value to show on the display.
REQ-011 Flags  out  4  {N,Z,C,V} from the last successful OP.
REQ-012 Depth  out  $clog2(DEPTH+1)  number of valid stack entries.
REQ-013 Error  out  1  sticky overflow/underflow indicator.
REQ-014 Busy  out  1  high while a command is executing.
REQ-015 CurrentState  out  3  one-hot FSM state: bit0 IDLE, bit1 EXEC, bit2 DONE.

Function
REQ-016 FSM transitions SHALL be: IDLE -> EXEC on Enter; EXEC -> DONE unconditionally; DONE -> IDLE unconditionally.
REQ-017 On Enter in IDLE, the block SHALL capture Cmd, OpCode and DataIn; later changes to these inputs SHALL NOT affect the command in progress.
REQ-018 Enter in EXEC or DONE SHALL be ignored and SHALL NOT be queued.
REQ-019 Busy SHALL be high exactly when the state is not IDLE.
REQ-020 All stack, Depth, Flags and Error updates SHALL occur at the clock edge that ends EXEC; results SHALL be visible in DONE, two cycles after the Enter cycle.
REQ-021 PUSH with Depth < DEPTH SHALL write the operand to the entry at index Depth and increment Depth.
REQ-022 PUSH with Depth = DEPTH SHALL set Error and leave the stack and Depth unchanged.
REQ-023 OP with Depth >= 2:
- A is the second-from-top entry; B is the top entry.
- The result A op B SHALL replace A.
- Depth SHALL decrement by one.
- Flags SHALL update.
REQ-024 OP with Depth < 2 SHALL set Error and leave the stack, Depth and Flags unchanged.
REQ-025 DROP with Depth >= 1 SHALL decrement Depth; DROP with Depth = 0 SHALL set Error.
REQ-026 CLEAR SHALL set Depth, Flags and Error to 0.
REQ-027 Flag rules:
- N is result[WIDTH-1].
- Z is 1 when result = 0.
- ADD: C is the carry out; V is signed overflow.
- SUB: C is the borrow (A < B, unsigned); V is signed overflow.
- AND and OR: C = V = 0.
REQ-028 Arithmetic SHALL be modulo 2^WIDTH.
REQ-029 Error SHALL be cleared only by CLEAR or reset; successful commands SHALL leave Error unchanged.
REQ-030 ToDisplay SHALL be combinational: DataIn when Depth = 0, otherwise the top entry.

Reset
REQ-031 While resetN = 0, the block SHALL immediately force state IDLE (CurrentState 001), Depth 0, Flags 0000, Error 0 and Busy 0, independent of clk.
REQ-032 Reset during EXEC or DONE SHALL abort the command with no partial update; stack RAM contents need not be reset.

Structure
REQ-033 Package rpn_pkg SHALL hold the cmd_t, op_t and state_t enums and the flag bit-index constants.
REQ-034 The stack storage, Depth counter and FSM SHALL be in rpn_stack_calculator.
REQ-035 The datapath SHALL be one combinational sub-module, rpn_alu (parameter WIDTH; ports a, b, op, result, flags).

Verification (WIDTH=16, DEPTH=4)
REQ-036 PUSH 0x0003, PUSH 0x0005, OP ADD -> ToDisplay 0x0008, Depth 1, Flags 0000, Error 0.
REQ-037 PUSH 0x0003, PUSH 0x0005, OP SUB -> ToDisplay 0xFFFE, Flags 1010.
REQ-038 PUSH 0x7FFF, PUSH 0x0001, OP ADD -> ToDisplay 0x8000, Flags 1001.
REQ-039 PUSH 1, 2, 3, 4, 5 -> Error 1 after the fifth, Depth 4, ToDisplay 0x0004; then CLEAR -> Error 0, Depth 0, ToDisplay = DataIn.
REQ-040 With Depth 1, OP AND -> Error 1, Depth 1, Flags unchanged.
REQ-041 Enter pulses in EXEC and in DONE -> ignored, Depth changes by exactly one.
REQ-042 resetN low during EXEC of a PUSH -> CurrentState 001 and Depth 0 without waiting for clk.
